// File: rtl/pe_vector_ctrl.sv
// Job sequencer for one PE column vector: broadcasts the instruction, gates a
// programmed number of ifmap/weight tokens into the column, then counts psum outputs.
module pe_vector_ctrl #(
    parameter int DATA_BITWIDTH = 8,
    parameter int CNT_BITWIDTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [2:0]               i_inst,
    input  logic [8:0]               i_conv_info,
    input  logic [CNT_BITWIDTH-1:0]  i_n_ifmap,
    input  logic [CNT_BITWIDTH-1:0]  i_n_wght,
    input  logic [CNT_BITWIDTH-1:0]  i_n_psum,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [2:0]               o_inst_data,
    output logic [8:0]               o_conv_info,
    output logic                     o_inst_valid,
    input  logic                     i_inst_ready,
    input  logic [DATA_BITWIDTH-1:0] i_glb_ifmap_data,
    input  logic                     i_glb_ifmap_valid,
    output logic                     o_glb_ifmap_ready,
    output logic [DATA_BITWIDTH-1:0] o_pe_ifmap_data,
    output logic                     o_pe_ifmap_valid,
    input  logic                     i_pe_ifmap_ready,
    input  logic [DATA_BITWIDTH-1:0] i_glb_wght_data,
    input  logic                     i_glb_wght_valid,
    output logic                     o_glb_wght_ready,
    output logic [DATA_BITWIDTH-1:0] o_pe_wght_data,
    output logic                     o_pe_wght_valid,
    input  logic                     i_pe_wght_ready,
    input  logic                     i_psum_out_valid,
    input  logic                     i_psum_out_ready,
    output logic [2:0]               o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INST   = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state_q;
    logic [2:0]              inst_q;
    logic [8:0]              conv_q;
    logic [CNT_BITWIDTH-1:0] n_ifmap_q, n_wght_q, n_psum_q;
    logic [CNT_BITWIDTH-1:0] ifmap_cnt_q, wght_cnt_q, psum_cnt_q;
    logic [CNT_BITWIDTH-1:0] ifmap_cnt_d, wght_cnt_d, psum_cnt_d;
    logic                    busy_q, done_q, inst_valid_q;

    logic en_ifmap, en_wght, ifmap_hs, wght_hs, psum_active, psum_hs;
    logic streams_closed, psum_met;

    // A transfer happens only in a cycle where valid and ready are both high;
    // valid never waits on ready, and a gate only masks the two signals together.
    assign en_ifmap    = (state_q == S_STREAM) && (ifmap_cnt_q != n_ifmap_q);
    assign en_wght     = (state_q == S_STREAM) && (wght_cnt_q != n_wght_q);
    assign ifmap_hs    = en_ifmap & i_glb_ifmap_valid & i_pe_ifmap_ready;
    assign wght_hs     = en_wght & i_glb_wght_valid & i_pe_wght_ready;
    assign psum_active = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign psum_hs     = psum_active & i_psum_out_valid & i_psum_out_ready &
                         (psum_cnt_q != n_psum_q);

    assign ifmap_cnt_d = ifmap_cnt_q + CNT_BITWIDTH'(ifmap_hs);
    assign wght_cnt_d  = wght_cnt_q + CNT_BITWIDTH'(wght_hs);
    assign psum_cnt_d  = psum_cnt_q + CNT_BITWIDTH'(psum_hs);

    // Next-cycle views so the exit decision includes this cycle's handshakes.
    assign streams_closed = (ifmap_cnt_d == n_ifmap_q) && (wght_cnt_d == n_wght_q);
    assign psum_met       = (psum_cnt_d == n_psum_q);

    assign o_pe_ifmap_valid  = i_glb_ifmap_valid & en_ifmap;
    assign o_glb_ifmap_ready = i_pe_ifmap_ready & en_ifmap;
    assign o_pe_ifmap_data   = i_glb_ifmap_data;
    assign o_pe_wght_valid   = i_glb_wght_valid & en_wght;
    assign o_glb_wght_ready  = i_pe_wght_ready & en_wght;
    assign o_pe_wght_data    = i_glb_wght_data;

    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_inst_valid = inst_valid_q;
    assign o_inst_data  = inst_q;
    assign o_conv_info  = conv_q;
    assign o_dbg_state  = state_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            inst_q       <= '0;
            conv_q       <= '0;
            n_ifmap_q    <= '0;
            n_wght_q     <= '0;
            n_psum_q     <= '0;
            ifmap_cnt_q  <= '0;
            wght_cnt_q   <= '0;
            psum_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            ifmap_cnt_q <= ifmap_cnt_d;
            wght_cnt_q  <= wght_cnt_d;
            psum_cnt_q  <= psum_cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        inst_q       <= i_inst;
                        conv_q       <= i_conv_info;
                        n_ifmap_q    <= i_n_ifmap;
                        n_wght_q     <= i_n_wght;
                        n_psum_q     <= i_n_psum;
                        ifmap_cnt_q  <= '0;
                        wght_cnt_q   <= '0;
                        psum_cnt_q   <= '0;
                        busy_q       <= 1'b1;
                        inst_valid_q <= 1'b1;
                        state_q      <= S_INST;
                    end
                end
                S_INST: begin
                    if (i_inst_ready) begin
                        inst_valid_q <= 1'b0;
                        if (n_ifmap_q != '0 || n_wght_q != '0) begin
                            state_q <= S_STREAM;
                        end else if (n_psum_q != '0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (streams_closed) begin
                        if (psum_met) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (psum_met) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    inst_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_vector_ctrl.sv
// Directed bench for pe_vector_ctrl: each step drives inputs after the rising
// edge and checks outputs with immediate assertions before the next edge.
module tb_pe_vector_ctrl;

    logic       clk;
    logic       i_rst, i_start, i_inst_ready;
    logic [2:0] i_inst;
    logic [8:0] i_conv_info;
    logic [7:0] i_n_ifmap, i_n_wght, i_n_psum;
    logic       o_busy, o_done, o_inst_valid;
    logic [2:0] o_inst_data, o_dbg_state;
    logic [8:0] o_conv_info;
    logic [7:0] i_glb_ifmap_data, o_pe_ifmap_data, i_glb_wght_data, o_pe_wght_data;
    logic       i_glb_ifmap_valid, o_glb_ifmap_ready, o_pe_ifmap_valid, i_pe_ifmap_ready;
    logic       i_glb_wght_valid, o_glb_wght_ready, o_pe_wght_valid, i_pe_wght_ready;
    logic       i_psum_out_valid, i_psum_out_ready;

    int n_assert = 0;
    int n_fail   = 0;
    int pe_if_hs = 0, glb_if_hs = 0, pe_w_hs = 0, glb_w_hs = 0;
    int done_seen = 0, valid_seen = 0;
    logic [7:0] exp_q[$];

    pe_vector_ctrl #(.DATA_BITWIDTH(8), .CNT_BITWIDTH(8)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_inst(i_inst),
        .i_conv_info(i_conv_info), .i_n_ifmap(i_n_ifmap), .i_n_wght(i_n_wght),
        .i_n_psum(i_n_psum), .o_busy(o_busy), .o_done(o_done),
        .o_inst_data(o_inst_data), .o_conv_info(o_conv_info),
        .o_inst_valid(o_inst_valid), .i_inst_ready(i_inst_ready),
        .i_glb_ifmap_data(i_glb_ifmap_data), .i_glb_ifmap_valid(i_glb_ifmap_valid),
        .o_glb_ifmap_ready(o_glb_ifmap_ready), .o_pe_ifmap_data(o_pe_ifmap_data),
        .o_pe_ifmap_valid(o_pe_ifmap_valid), .i_pe_ifmap_ready(i_pe_ifmap_ready),
        .i_glb_wght_data(i_glb_wght_data), .i_glb_wght_valid(i_glb_wght_valid),
        .o_glb_wght_ready(o_glb_wght_ready), .o_pe_wght_data(o_pe_wght_data),
        .o_pe_wght_valid(o_pe_wght_valid), .i_pe_wght_ready(i_pe_wght_ready),
        .i_psum_out_valid(i_psum_out_valid), .i_psum_out_ready(i_psum_out_ready),
        .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer monitor on the falling edge, where inputs and outputs are settled.
    always @(negedge clk) begin
        if (o_pe_ifmap_valid && i_pe_ifmap_ready) pe_if_hs++;
        if (o_glb_ifmap_ready && i_glb_ifmap_valid) glb_if_hs++;
        if (o_pe_wght_valid && i_pe_wght_ready) pe_w_hs++;
        if (o_glb_wght_ready && i_glb_wght_valid) glb_w_hs++;
        if (o_done) done_seen++;
        if (o_pe_ifmap_valid || o_pe_wght_valid) valid_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [2:0] inst, input logic [8:0] conv,
                             input logic [7:0] ni, input logic [7:0] nw, input logic [7:0] np);
        i_start = 1'b1;
        i_inst = inst;
        i_conv_info = conv;
        i_n_ifmap = ni;
        i_n_wght = nw;
        i_n_psum = np;
        tick();
        i_start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_inst_valid"}, o_inst_valid, 0);
        chk({tag, "_inst_data"}, o_inst_data, 0);
        chk({tag, "_conv_info"}, o_conv_info, 0);
        chk({tag, "_pe_ifmap_valid"}, o_pe_ifmap_valid, 0);
        chk({tag, "_pe_wght_valid"}, o_pe_wght_valid, 0);
        chk({tag, "_glb_ifmap_ready"}, o_glb_ifmap_ready, 0);
        chk({tag, "_glb_wght_ready"}, o_glb_wght_ready, 0);
        chk({tag, "_state"}, o_dbg_state, 0);
    endtask

    initial begin
        int b_pif, b_gif, b_pw, b_gw, b_done, b_valid;
        int cnt_if, cnt_w, guard, k;
        logic [7:0] exp_tok;

        i_rst = 1'b0; i_start = 1'b0; i_inst = '0; i_conv_info = '0;
        i_n_ifmap = '0; i_n_wght = '0; i_n_psum = '0; i_inst_ready = 1'b0;
        i_glb_ifmap_data = '0; i_glb_ifmap_valid = 1'b0; i_pe_ifmap_ready = 1'b0;
        i_glb_wght_data = '0; i_glb_wght_valid = 1'b0; i_pe_wght_ready = 1'b0;
        i_psum_out_valid = 1'b0; i_psum_out_ready = 1'b0;
        tick();
        tick();
        check_idle_outputs("reset");
        i_rst = 1'b1;
        tick();

        // Basic job 4/3/2 with every channel ready.
        i_glb_ifmap_valid = 1'b1; i_pe_ifmap_ready = 1'b1;
        i_glb_wght_valid = 1'b1; i_pe_wght_ready = 1'b1; i_inst_ready = 1'b1;
        i_glb_ifmap_data = 8'h3C; i_glb_wght_data = 8'hC3;
        b_pif = pe_if_hs; b_gif = glb_if_hs; b_pw = pe_w_hs; b_gw = glb_w_hs;
        start_job(3'b101, 9'h155, 8'd4, 8'd3, 8'd2);
        chk("basic_inst_valid", o_inst_valid, 1);
        chk("basic_inst_data", o_inst_data, 3'b101);
        chk("basic_conv_info", o_conv_info, 9'h155);
        chk("basic_busy", o_busy, 1);
        chk("basic_state_inst", o_dbg_state, 1);
        chk("basic_gate_closed_inst", o_glb_ifmap_ready, 0);
        tick();
        chk("basic_state_stream", o_dbg_state, 2);
        chk("basic_inst_valid_drop", o_inst_valid, 0);
        chk("basic_pe_ifmap_valid", o_pe_ifmap_valid, 1);
        chk("basic_glb_wght_ready", o_glb_wght_ready, 1);
        chk("basic_ifmap_data", o_pe_ifmap_data, 8'h3C);
        chk("basic_wght_data", o_pe_wght_data, 8'hC3);
        repeat (4) tick();
        chk("basic_state_drain", o_dbg_state, 3);
        chk("basic_pe_ifmap_valid_off", o_pe_ifmap_valid, 0);
        chk("basic_glb_ifmap_ready_off", o_glb_ifmap_ready, 0);
        chk("basic_pe_wght_valid_off", o_pe_wght_valid, 0);
        chk("basic_glb_wght_ready_off", o_glb_wght_ready, 0);
        chk("basic_pe_ifmap_count", pe_if_hs - b_pif, 4);
        chk("basic_glb_ifmap_count", glb_if_hs - b_gif, 4);
        chk("basic_pe_wght_count", pe_w_hs - b_pw, 3);
        chk("basic_glb_wght_count", glb_w_hs - b_gw, 3);
        i_psum_out_valid = 1'b1; i_psum_out_ready = 1'b1;
        tick();
        chk("basic_done_after_psum1", o_done, 0);
        chk("basic_state_drain_psum1", o_dbg_state, 3);
        tick();
        chk("basic_done_pulse", o_done, 1);
        chk("basic_state_done", o_dbg_state, 4);
        i_psum_out_valid = 1'b0;
        tick();
        chk("basic_done_low", o_done, 0);
        chk("basic_busy_low", o_busy, 0);

        // Backpressure: instruction held off, then random stalls on both streams.
        // Psum traffic during INST must not count toward the target of 1.
        i_inst_ready = 1'b0; i_psum_out_valid = 1'b1; i_psum_out_ready = 1'b1;
        b_pif = pe_if_hs; b_gif = glb_if_hs; b_pw = pe_w_hs; b_gw = glb_w_hs;
        start_job(3'b011, 9'h0A6, 8'd4, 8'd3, 8'd1);
        chk("bp_inst_valid_rise", o_inst_valid, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_inst_valid_held", o_inst_valid, 1);
            chk("bp_inst_data_stable", o_inst_data, 3'b011);
            chk("bp_conv_info_stable", o_conv_info, 9'h0A6);
            chk("bp_state_inst", o_dbg_state, 1);
        end
        i_inst_ready = 1'b1; i_psum_out_valid = 1'b0;
        tick();
        chk("bp_state_stream", o_dbg_state, 2);
        chk("bp_inst_valid_drop", o_inst_valid, 0);
        cnt_if = 0; cnt_w = 0; guard = 0;
        while (!(cnt_if == 4 && cnt_w == 3) && guard < 200) begin
            i_pe_ifmap_ready = 1'($urandom_range(0, 1));
            i_glb_wght_valid = 1'($urandom_range(0, 1));
            #1;
            chk("bp_pe_ifmap_valid", o_pe_ifmap_valid, (cnt_if != 4));
            chk("bp_glb_ifmap_ready", o_glb_ifmap_ready, (i_pe_ifmap_ready && cnt_if != 4));
            chk("bp_pe_wght_valid", o_pe_wght_valid, (i_glb_wght_valid && cnt_w != 3));
            chk("bp_glb_wght_ready", o_glb_wght_ready, (cnt_w != 3));
            if (i_pe_ifmap_ready && cnt_if != 4) cnt_if++;
            if (i_glb_wght_valid && cnt_w != 3) cnt_w++;
            guard++;
            tick();
        end
        chk("bp_within_budget", (guard < 200), 1);
        chk("bp_state_drain", o_dbg_state, 3);
        chk("bp_no_done_yet", o_done, 0);
        chk("bp_pe_ifmap_count", pe_if_hs - b_pif, 4);
        chk("bp_glb_ifmap_count", glb_if_hs - b_gif, 4);
        chk("bp_pe_wght_count", pe_w_hs - b_pw, 3);
        chk("bp_glb_wght_count", glb_w_hs - b_gw, 3);
        i_pe_ifmap_ready = 1'b1; i_glb_wght_valid = 1'b1; i_psum_out_valid = 1'b1;
        tick();
        chk("bp_done_pulse", o_done, 1);
        i_psum_out_valid = 1'b0;
        tick();
        chk("bp_busy_low", o_busy, 0);

        // Over-supply: GLB offers ten ifmap tokens, only four may pass.
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(8'h10 + i));
        b_done = done_seen;
        start_job(3'b001, 9'h003, 8'd4, 8'd0, 8'd0);
        tick();
        chk("os_state_stream", o_dbg_state, 2);
        k = 0;
        for (int c = 0; c < 12; c++) begin
            i_glb_ifmap_valid = (k < 10);
            i_glb_ifmap_data = 8'(8'h10 + k);
            #1;
            chk("os_glb_ifmap_ready", o_glb_ifmap_ready, (k < 4));
            if (o_glb_ifmap_ready && i_glb_ifmap_valid) begin
                exp_tok = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                chk("os_token_data", o_pe_ifmap_data, exp_tok);
                k++;
            end
            tick();
        end
        chk("os_accepted", k, 4);
        chk("os_done_count", done_seen - b_done, 1);
        chk("os_busy_low", o_busy, 0);
        i_glb_ifmap_valid = 1'b1;

        // Zero counts: INST goes straight to DONE.
        b_done = done_seen; b_valid = valid_seen;
        start_job(3'b110, 9'h1FF, 8'd0, 8'd0, 8'd0);
        chk("zero_state_inst", o_dbg_state, 1);
        chk("zero_no_done_yet", o_done, 0);
        tick();
        chk("zero_done_pulse", o_done, 1);
        chk("zero_state_done", o_dbg_state, 4);
        tick();
        chk("zero_done_low", o_done, 0);
        chk("zero_busy_low", o_busy, 0);
        chk("zero_no_stream_valid", valid_seen - b_valid, 0);
        chk("zero_done_count", done_seen - b_done, 1);

        // Early psum: three psum handshakes during STREAM against a target of two.
        i_psum_out_valid = 1'b1; i_psum_out_ready = 1'b1;
        start_job(3'b010, 9'h021, 8'd3, 8'd2, 8'd2);
        tick();
        chk("ep_state_stream1", o_dbg_state, 2);
        tick();
        chk("ep_state_stream2", o_dbg_state, 2);
        tick();
        chk("ep_state_stream3", o_dbg_state, 2);
        tick();
        chk("ep_done_pulse", o_done, 1);
        chk("ep_state_done", o_dbg_state, 4);
        i_psum_out_valid = 1'b0;
        tick();
        chk("ep_busy_low", o_busy, 0);

        // Abort mid-STREAM, with a stray start while busy.
        b_done = done_seen;
        start_job(3'b100, 9'h0F0, 8'd4, 8'd3, 8'd2);
        chk("ab_inst_data", o_inst_data, 3'b100);
        i_start = 1'b1; i_inst = 3'b111; i_conv_info = 9'h1E1; i_n_ifmap = 8'd9;
        tick();
        i_start = 1'b0;
        chk("ab_stray_state", o_dbg_state, 2);
        chk("ab_stray_inst_data", o_inst_data, 3'b100);
        chk("ab_stray_conv_info", o_conv_info, 9'h0F0);
        tick();
        i_rst = 1'b0;
        tick();
        check_idle_outputs("abort");
        i_rst = 1'b1;
        tick();
        chk("ab_no_done", done_seen - b_done, 0);
        chk("ab_state_idle", o_dbg_state, 0);
        b_pif = pe_if_hs; b_pw = pe_w_hs;
        start_job(3'b011, 9'h1C7, 8'd2, 8'd1, 8'd0);
        chk("clean_inst_data", o_inst_data, 3'b011);
        chk("clean_conv_info", o_conv_info, 9'h1C7);
        tick();
        chk("clean_state_stream", o_dbg_state, 2);
        tick();
        tick();
        chk("clean_done_pulse", o_done, 1);
        tick();
        chk("clean_busy_low", o_busy, 0);
        chk("clean_pe_ifmap_count", pe_if_hs - b_pif, 2);
        chk("clean_pe_wght_count", pe_w_hs - b_pw, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
